// File: rtl/ram_arbiter_rr.sv
// N-port arbiter onto a single-port RAM with narrow-master width adaptation.
// Fixed-priority or round-robin grant; a response pipeline routes each read lane back to its issuer.
module ram_arbiter_rr #(
   parameter int NUM_PORTS   = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int OUT_WIDTH   = 32,
   parameter int IN_WIDTH    = 32,
   parameter int RAM_LATENCY = 1,
   parameter int RR_MODE     = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            req_i,
   output logic [NUM_PORTS-1:0]            gnt_o,
   output logic [NUM_PORTS-1:0]            rvalid_o,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_PORTS-1:0]            we_i,
   input  logic [NUM_PORTS*IN_WIDTH/8-1:0] be_i,
   input  logic [NUM_PORTS*IN_WIDTH-1:0]   wdata_i,
   output logic [NUM_PORTS*IN_WIDTH-1:0]   rdata_o,
   output logic                            ram_en_o,
   output logic [ADDR_WIDTH-1:0]           ram_addr_o,
   output logic                            ram_we_o,
   output logic [OUT_WIDTH/8-1:0]          ram_be_o,
   output logic [OUT_WIDTH-1:0]            ram_wdata_o,
   input  logic [OUT_WIDTH-1:0]            ram_rdata_i
);

   localparam int LANES = OUT_WIDTH / IN_WIDTH;
   localparam int IBE   = IN_WIDTH / 8;
   localparam int OBE   = OUT_WIDTH / 8;
   localparam int PW    = $clog2(NUM_PORTS);
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   if (IN_WIDTH > OUT_WIDTH || IN_WIDTH < 8 || OUT_WIDTH < 8 ||
       (IN_WIDTH & (IN_WIDTH - 1)) != 0 || (OUT_WIDTH & (OUT_WIDTH - 1)) != 0) begin : g_bad_width
      $error("ram_arbiter_rr: illegal IN_WIDTH/OUT_WIDTH combination");
   end
   if (NUM_PORTS < 2 || RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_param
      $error("ram_arbiter_rr: illegal NUM_PORTS or RAM_LATENCY");
   end

   logic [PW-1:0]         ptr;
   logic [PW-1:0]         win;
   logic [PW-1:0]         cand;
   logic                  found;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [IBE-1:0]        win_be;
   logic [IN_WIDTH-1:0]   win_wdata;
   logic [LW-1:0]         win_lane;
   logic [IN_WIDTH-1:0]   rd_lane_data;

   logic [RAM_LATENCY-1:0] vld_p;
   logic [PW-1:0]          port_p [RAM_LATENCY];
   logic [LW-1:0]          lane_p [RAM_LATENCY];

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      return sum[PW-1:0];
   endfunction

   // Arbitration: search starts at ptr (round-robin) or port 0 (fixed priority)
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = (RR_MODE != 0) ? wrap_idx(ptr, i) : PW'(i);
         if (!found && req_i[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_o = '0;
      if (found) gnt_o[win] = 1'b1;
   end

   assign win_addr  = addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
   assign win_be    = be_i[win*IBE +: IBE];
   assign win_wdata = wdata_i[win*IN_WIDTH +: IN_WIDTH];

   if (LANES > 1) begin : g_lane
      assign win_lane = win_addr[$clog2(OBE)-1 : $clog2(IBE)];
   end else begin : g_no_lane
      assign win_lane = '0;
   end

   assign ram_en_o    = |req_i;
   assign ram_addr_o  = win_addr;
   assign ram_we_o    = we_i[win];
   assign ram_be_o    = OBE'(win_be) << (win_lane * IBE);
   assign ram_wdata_o = {LANES{win_wdata}};

   // Stage boundary: response pipeline, valid bits and ptr are the only reset state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         vld_p <= '0;
      end else begin
         if (found) ptr <= wrap_idx(win, 1);
         vld_p[0] <= found;
         for (int s = 1; s < RAM_LATENCY; s++) vld_p[s] <= vld_p[s-1];
      end
   end

   always_ff @(posedge clk) begin
      port_p[0] <= win;
      lane_p[0] <= win_lane;
      for (int s = 1; s < RAM_LATENCY; s++) begin
         port_p[s] <= port_p[s-1];
         lane_p[s] <= lane_p[s-1];
      end
   end

   // Stage boundary: final stage steers the response
   always_comb begin
      rvalid_o = '0;
      if (vld_p[RAM_LATENCY-1]) rvalid_o[port_p[RAM_LATENCY-1]] = 1'b1;
   end

   assign rd_lane_data = ram_rdata_i[lane_p[RAM_LATENCY-1]*IN_WIDTH +: IN_WIDTH];
   assign rdata_o      = {NUM_PORTS{rd_lane_data}};

endmodule
